// File: rtl/lmem_arbiter.sv
// Layer-memory port arbiter: round-robin grant with burst lock, registered memory side, routed read return.
// Optional LMEM_ARB_FIXED_PRIO_EN: lowest-index priority, no round-robin pointer, no MAX_BURST pre-emption.
module lmem_arbiter #(
  parameter int unsigned NREQ      = 3,
  parameter int unsigned AW        = 12,
  parameter int unsigned DW        = 20,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      lock,
  input  logic [NREQ-1:0]      wr,
  input  logic [3*NREQ-1:0]    sel,
  input  logic [AW*NREQ-1:0]   addr,
  input  logic [DW*NREQ-1:0]   wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rvalid,
  output logic [DW-1:0]        rdata,
  output logic                 cwr,
  output logic                 crd,
  output logic [2:0]           csel,
  output logic [AW-1:0]        caddr_wr,
  output logic [AW-1:0]        caddr_rd,
  output logic [DW-1:0]        cdata_wr,
  input  logic [DW-1:0]        cdata_rd
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {ST_IDLE, ST_OWN} state_t;

  state_t          r_state;
  logic [IW-1:0]   r_own;
  logic [IW-1:0]   r_rd_id;
`ifndef LMEM_ARB_FIXED_PRIO_EN
  logic [IW-1:0]   r_rr;
  int unsigned     w_dist;
  int unsigned     w_best;
`endif
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_rvalid;
  logic [7:0]      r_burst;
  logic            r_cwr;
  logic            r_crd;
  logic [2:0]      r_csel;
  logic [AW-1:0]   r_caddr_wr;
  logic [AW-1:0]   r_caddr_rd;
  logic [DW-1:0]   r_cdata_wr;
  logic [DW-1:0]   r_rdata;

  logic            w_req_k, w_lock_k, w_wr_k, w_other;
  logic [2:0]      w_sel_k;
  logic [AW-1:0]   w_addr_k;
  logic [DW-1:0]   w_wdata_k;
  logic [NREQ-1:0] w_rd_oh;
  logic            w_pick_vld;
  logic [IW-1:0]   w_pick;
  logic [NREQ-1:0] w_pick_oh;
  logic            w_acc;
  logic [7:0]      w_burst_nx;
  logic            w_release;

  always_comb begin
    w_req_k   = 1'b0;
    w_lock_k  = 1'b0;
    w_wr_k    = 1'b0;
    w_other   = 1'b0;
    w_sel_k   = '0;
    w_addr_k  = '0;
    w_wdata_k = '0;
    w_rd_oh   = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (r_own == IW'(j)) begin
        w_req_k   = req[j];
        w_lock_k  = lock[j];
        w_wr_k    = wr[j];
        w_sel_k   = sel[3*j +: 3];
        w_addr_k  = addr[AW*j +: AW];
        w_wdata_k = wdata[DW*j +: DW];
      end else begin
        w_other = w_other | req[j];
      end
      w_rd_oh[j] = (r_rd_id == IW'(j));
    end
  end

  always_comb begin
    w_pick_vld = 1'b0;
    w_pick     = '0;
    w_pick_oh  = '0;
`ifdef LMEM_ARB_FIXED_PRIO_EN
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (req[j] && !w_pick_vld) begin
        w_pick_vld = 1'b1;
        w_pick     = IW'(j);
      end
    end
`else
    w_dist = 0;
    w_best = 0;
    // Distance from rr+1 (mod NREQ); the nearest requesting index wins.
    for (int unsigned j = 0; j < NREQ; j++) begin
      w_dist = (j + NREQ - 1 - 32'(r_rr)) % NREQ;
      if (req[j] && (!w_pick_vld || w_dist < w_best)) begin
        w_pick_vld = 1'b1;
        w_best     = w_dist;
        w_pick     = IW'(j);
      end
    end
`endif
    for (int unsigned j = 0; j < NREQ; j++)
      w_pick_oh[j] = (w_pick == IW'(j));
  end

  assign w_acc      = (r_state == ST_OWN) && w_req_k;
  assign w_burst_nx = (w_acc && r_burst != 8'(MAX_BURST)) ? r_burst + 8'd1 : r_burst;

`ifdef LMEM_ARB_FIXED_PRIO_EN
  assign w_release = !w_req_k && !w_lock_k;
`else
  // Pre-emption uses the post-accept count so the owner gets exactly MAX_BURST accesses.
  assign w_release = (!w_req_k && !w_lock_k) ||
                     (!w_lock_k && w_other && w_burst_nx == 8'(MAX_BURST));
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_own      <= '0;
      r_rd_id    <= '0;
`ifndef LMEM_ARB_FIXED_PRIO_EN
      r_rr       <= IW'(NREQ - 1);
`endif
      r_gnt      <= '0;
      r_rvalid   <= '0;
      r_burst    <= '0;
      r_cwr      <= 1'b0;
      r_crd      <= 1'b0;
      r_csel     <= '0;
      r_caddr_wr <= '0;
      r_caddr_rd <= '0;
      r_cdata_wr <= '0;
      r_rdata    <= '0;
    end else begin
      r_cwr    <= 1'b0;
      r_crd    <= 1'b0;
      r_rvalid <= '0;
      if (r_crd) begin
        r_rdata  <= cdata_rd;
        r_rvalid <= w_rd_oh;
      end
      if (w_acc) begin
        r_csel <= w_sel_k;
        if (w_wr_k) begin
          r_cwr      <= 1'b1;
          r_caddr_wr <= w_addr_k;
          r_cdata_wr <= w_wdata_k;
        end else begin
          r_crd      <= 1'b1;
          r_caddr_rd <= w_addr_k;
          r_rd_id    <= r_own;
        end
      end
      case (r_state)
        ST_IDLE: begin
          if (w_pick_vld) begin
            r_state <= ST_OWN;
            r_own   <= w_pick;
            r_gnt   <= w_pick_oh;
            r_burst <= '0;
          end
        end
        ST_OWN: begin
          r_burst <= w_burst_nx;
          if (w_release) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
`ifndef LMEM_ARB_FIXED_PRIO_EN
            r_rr    <= r_own;
`endif
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign gnt      = r_gnt;
  assign rvalid   = r_rvalid;
  assign rdata    = r_rdata;
  assign cwr      = r_cwr;
  assign crd      = r_crd;
  assign csel     = r_csel;
  assign caddr_wr = r_caddr_wr;
  assign caddr_rd = r_caddr_rd;
  assign cdata_wr = r_cdata_wr;

endmodule

// File: doc/lmem_arbiter.md
Name: lmem_arbiter

Overview:
- Arbitrates the single layer-memory port (cwr/crd/csel/caddr_wr/caddr_rd/cdata_wr/cdata_rd) between NREQ requesters: conv writer, ReLU/pool engine, result-dump reader.
- Round-robin grant with burst lock.
- Registers all memory-side outputs.
- Returns read data with a valid strobe to the owning requester only.

Parameters:
- NREQ, 3, number of requesters; requester index i occupies slice i of each flattened bus.
- AW, 12, memory address width.
- DW, 20, memory data width.
- MAX_BURST, 16, granted accesses after which an unlocked owner is pre-empted when another requester waits; range 1..255.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester access request, held until accepted.
- lock  in  NREQ  owner keeps grant while high, even with req low.
- wr  in  NREQ  1 = write, 0 = read, qualified by req.
- sel  in  3*NREQ  memory select per requester.
- addr  in  AW*NREQ  access address per requester.
- wdata  in  DW*NREQ  write data per requester.
- gnt  out  NREQ  one-hot registered owner; all zero when idle.
- rvalid  out  NREQ  one-cycle read-data strobe to the requester that issued the read.
- rdata  out  DW  registered read data, shared by all requesters.
- cwr  out  1  memory write strobe.
- crd  out  1  memory read strobe.
- csel  out  3  memory select.
- caddr_wr  out  AW  write address.
- caddr_rd  out  AW  read address.
- cdata_wr  out  DW  write data.
- cdata_rd  in  DW  memory read data, valid while crd is high.

Behaviour:
- Reset (reset low, asynchronous) clears:
  - gnt, rvalid, cwr, crd, csel, caddr_wr, caddr_rd, cdata_wr, rdata;
  - burst counter;
  - rr pointer, set to NREQ-1 so requester 0 wins first.
- State machine:
  - IDLE: gnt=0. If any req is high, the next edge sets gnt to the first requester with req high, scanning from rr+1 modulo NREQ. Go to OWN.
  - OWN: owner k. The next edge returns to IDLE, clears gnt and sets rr=k when any release condition holds:
    - req[k]=0 and lock[k]=0;
    - lock[k]=0, burst counter = MAX_BURST, and another req is high.
  - IDLE→OWN and OWN→IDLE each take one edge, so a handover leaves exactly one idle cycle (no back-to-back owner switch).
  - lock high with req low holds OWN with no accesses.
- Accept:
  - An access is accepted on an edge where gnt[k]=1 and req[k]=1; one access per cycle.
  - Burst counter increments per accept, saturates at MAX_BURST, clears on entering OWN.
- Memory side, registered. On the edge after accept:
  - csel = sel[k].
  - Write: cwr=1, caddr_wr=addr[k], cdata_wr=wdata[k].
  - Read: crd=1, caddr_rd=addr[k].
  - cwr/crd are low in cycles with no accept.
  - csel, addresses and cdata_wr hold their last values when idle.
- Read return:
  - In the cycle crd=1, cdata_rd is captured.
  - Next cycle: rdata = captured value, rvalid[k]=1 for one cycle.
  - Read latency is 2 cycles from accept edge to rvalid.
  - rvalid goes to the issuing requester even if it lost the grant in the meantime.
- cwr and crd are never high in the same cycle.
- Accesses already accepted complete even if the owner releases.
- Requests with gnt low are ignored; requesters must hold req, wr, sel, addr and wdata stable until accepted.
- Reset asserted mid-burst:
  - All strobes drop immediately.
  - A pending read return is discarded; no rvalid after reset deasserts.

Optional Feature:
- LMEM_ARB_FIXED_PRIO_EN.
- Defined: IDLE grants the lowest-index requester with req high; rr is unused and MAX_BURST pre-emption is disabled. An owner is released only when its req and lock are both low.
- Undefined: round-robin and MAX_BURST pre-emption as described above.

Test Plan:
- Single requester: req[0]=1 write, sel=1, addr=0x123, wdata=0x0A89E → gnt=001 one cycle later; on the edge after accept cwr=1, csel=1, caddr_wr=0x123, cdata_wr=0x0A89E; crd=0.
- Read latency: requester 2 reads addr 0xFFF, memory returns 0x01310 while crd=1 → rvalid=100 and rdata=0x01310 exactly two cycles after accept; rvalid[0] and rvalid[1] stay 0.
- Round-robin: req=111 held continuously, lock=0, MAX_BURST=4 → grants 0,1,2,0,…; each owner gets 4 accepts followed by one idle gnt=000 cycle.
- Lock: requester 1 holds lock=1 for 40 cycles with req toggling; req[0] and req[2] high → gnt stays 010 beyond MAX_BURST; releases the edge after lock and req both drop.
- Reset mid-read: assert reset the cycle crd=1 → cwr, crd, gnt and rvalid are 0 immediately; after release, gnt=001 first when req=111.
- With LMEM_ARB_FIXED_PRIO_EN defined and req=111 held → gnt stays 001 indefinitely; requesters 1 and 2 are never granted.
